// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes and
// the select codes decoded by the datapath muxes and the ALU decoder.
package mips_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_out_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_out_decode.sv
// Combinational output map for the main control FSM: Moore decode of state,
// with mem_ready qualifying the FETCH loads and op qualifying illegal_op.
module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_e          state,
  input  logic            mem_ready,
  input  logic [OP_W-1:0] op,
  output ctrl_out_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb    = SRCB_IMMSH2;
        ctrl.illegal_op = !is_legal_op(op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      // Write strobe stays up across every wait cycle of the store.
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register and next-state logic; the
// output map lives in mips_ctrl_out_decode.
module mips_main_ctrl_fsm #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);
  import mips_ctrl_pkg::*;

  state_e    state_q, state_d;
  ctrl_out_t dec_ctrl, ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mips_ctrl_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .op        (op),
    .ctrl      (dec_ctrl)
  );

  // Reset blanks every strobe immediately so an aborted instruction writes nothing.
  assign ctrl = rst_n ? dec_ctrl : '0;

  assign pcwrite    = ctrl.pcwrite;
  assign branch     = ctrl.branch;
  assign iord       = ctrl.iord;
  assign memwrite   = ctrl.memwrite;
  assign irwrite    = ctrl.irwrite;
  assign memtoreg   = ctrl.memtoreg;
  assign regdst     = ctrl.regdst;
  assign regwrite   = ctrl.regwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign aluop      = ctrl.aluop;
  assign illegal_op = ctrl.illegal_op;
  assign state_o    = state_q;

endmodule

// File: doc/mips_main_ctrl_fsm.md
Name: mips_main_ctrl_fsm

Overview:
Multicycle MIPS main control unit. Sequences every instruction through fetch, decode, execute, memory and writeback states. Drives the enable strobes and the 2-bit select lines consumed by the datapath 4:1 multiplexors (ALU source B, PC source). It is the producer side of the select interface those muxes decode. It also handles a memory-ready handshake so memory states stretch across wait cycles.

Parameters:
OP_W, 6, opcode width (instr[31:26])
STATE_W, 4, state register width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
op  in  OP_W  opcode of instruction register
mem_ready  in  1  memory completes current access this cycle
pcwrite  out  1  unconditional PC load
branch  out  1  PC load qualified by ALU zero (ANDed in datapath)
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
memtoreg  out  1  regfile write data: 0=ALUOut, 1=MDR
regdst  out  1  regfile write address: 0=rt, 1=rd
regwrite  out  1  regfile write enable
alusrca  out  1  ALU A: 0=PC, 1=reg A
alusrcb  out  2  ALU B: 00=reg B, 01=const 4, 10=signimm, 11=signimm<<2
pcsrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target, 11=unused (treated as 00)
aluop  out  2  00=add, 01=sub, 10=use funct, 11=reserved
illegal_op  out  1  one-cycle pulse, unsupported opcode seen in DECODE
state_o  out  STATE_W  current state (debug/verification)

Behaviour:
- State register updates only on rising clk. When rst_n=0 at an edge, state<=FETCH.
- While rst_n=0, all outputs are combinationally forced to 0, including illegal_op. state_o shows the registered state. No datapath write occurs during reset.
- Outputs are a Moore decode of state. The only exceptions are the mem_ready qualification in FETCH and the illegal_op qualification in DECODE.
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, ADDI=001000, J=000010.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Values 12-15 are illegal and go to FETCH on the next edge with all outputs 0.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Stays in FETCH while mem_ready=0, otherwise goes to DECODE.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
  - Next state by op: LW/SW->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, ADDI->ADDIEX, J->JEX.
  - Any other op->FETCH with illegal_op=1 for this cycle only.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if op=LW, else to MEMWR.
- MEMRD: iord=1. Holds while mem_ready=0, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then goes to FETCH.
- MEMWR:
  - iord=1, memwrite=1, held high on every wait cycle.
  - Holds while mem_ready=0, then goes to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10, then goes to RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, then goes to FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, then goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, then goes to ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, then goes to FETCH.
- JEX: pcsrc=10, pcwrite=1, then goes to FETCH.
- Any output not listed for a state is 0.
- Latency with mem_ready=1 throughout: LW=5 cycles, SW=4, RTYPE=4, ADDI=4, BEQ=3, J=3, illegal=2.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset asserted mid-instruction aborts the instruction: no further writes issue, and FETCH follows on the next edge.
- op is sampled only in DECODE and MEMADR. op changing in other states has no effect.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state localparams and STATE_W;
  - opcode constants;
  - alusrcb, pcsrc and aluop encodings, which are shared with the datapath mux instances and the ALU decoder.
- One sub-module, mips_ctrl_out_decode: a purely combinational map from state, mem_ready and op to the output vector. The top holds the state register and next-state logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> all outputs 0 during reset; after release state_o=0 and FETCH shows irwrite=pcwrite=1, alusrcb=01.
- LW, mem_ready=1: op=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; 5 cycles total.
- SW with stall: op=101011, mem_ready=0 for 2 cycles in MEMWR -> memwrite=1 for 3 consecutive cycles; sequence 0,1,2,5,5,5,0.
- BEQ/J: op=000100 -> BEQEX shows branch=1, pcsrc=01, aluop=01. op=000010 -> JEX shows pcwrite=1, pcsrc=10. Each takes 3 cycles.
- Illegal opcode 111111 -> illegal_op pulses exactly 1 cycle in DECODE, returns to FETCH, and no regwrite or memwrite is asserted.
- Reset mid-op: assert rst_n=0 in MEMRD of a LW -> outputs 0 immediately, FETCH next edge, and no MEMWB regwrite ever occurs.
